// File: rtl/mod_n_down_counter_pkg.sv
// Shared defaults and helpers for the modulo-N counter family (up and down variants).
package mod_n_down_counter_pkg;

  localparam int DEF_MODULUS = 7;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_WIDTH = clog2(DEF_MODULUS);

  // Value a down counter reloads to after passing zero.
  function automatic int reload_value(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/mod_n_down_counter_t_ff_ld.sv
// One counter bit: T flip-flop with synchronous parallel load and asynchronous reset to rst_val.
module t_ff_ld (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/mod_n_down_counter.sv
// Modulo-N down counter built from T flip-flops; cascadable through en / borrow_out.
module mod_n_down_counter
  import mod_n_down_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow_out,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(reload_value(MODULUS));

  logic             in_range;
  logic             ld_all;
  logic [WIDTH-1:0] d_val;
  logic [WIDTH-1:0] t_vec;

  // Widen by one bit so MODULUS == 2**WIDTH compares correctly (always in range).
  assign in_range   = ({1'b0, load_val} < (WIDTH + 1)'(MODULUS));
  assign zero       = (count == '0);
  assign borrow_out = en & zero;

  // The reload path replaces the 0 -> all-ones toggle so non-power-of-2 moduli wrap to MODULUS-1.
  assign ld_all = load | (en & zero);
  assign d_val  = (load && in_range) ? load_val : RELOAD;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign t_vec[i] = en;
    end else begin : g_upper
      assign t_vec[i] = en & ~(|count[i-1:0]);
    end

    t_ff_ld u_bit (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RELOAD[i]),
      .t       (t_vec[i]),
      .ld      (ld_all),
      .d       (d_val[i]),
      .q       (count[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap <= ~load & en & zero;
      if (load) begin
        load_err <= ~in_range;
      end
    end
  end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Randomised and directed checks of mod_n_down_counter against an arithmetic reference model.
module tb_mod_n_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       casc_en = 1'b0;
  logic       casc_load = 1'b0;
  logic [2:0] casc_lv = 3'd0;

  logic [2:0] c7, c8, ca, cb;
  logic       z7, b7, w7, e7;
  logic       z8, b8, w8, e8;
  logic       za, ba, wa, ea;
  logic       zb, bb, wb, eb;

  int total = 0;
  int bad = 0;

  // Reference model state: plain integers updated by modular arithmetic.
  int m7_c = 6, m7_w = 0, m7_e = 0;
  int m8_c = 7, m8_w = 0, m8_e = 0;
  int ma_c = 6, mb_c = 6;

  always #5 clk = ~clk;

  mod_n_down_counter #(.WIDTH(3), .MODULUS(7)) dut7 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(c7), .zero(z7), .borrow_out(b7), .wrap(w7), .load_err(e7)
  );

  mod_n_down_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(c8), .zero(z8), .borrow_out(b8), .wrap(w8), .load_err(e8)
  );

  mod_n_down_counter #(.WIDTH(3), .MODULUS(7)) casc_a (
    .clk(clk), .rst(rst), .en(casc_en), .load(casc_load), .load_val(casc_lv),
    .count(ca), .zero(za), .borrow_out(ba), .wrap(wa), .load_err(ea)
  );

  mod_n_down_counter #(.WIDTH(3), .MODULUS(7)) casc_b (
    .clk(clk), .rst(rst), .en(ba), .load(casc_load), .load_val(casc_lv),
    .count(cb), .zero(zb), .borrow_out(bb), .wrap(wb), .load_err(eb)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt_count(input int m, input int c, input int ld, input int e, input int lv);
    if (ld != 0) return (lv < m) ? lv : m - 1;
    if (e != 0) return (c + m - 1) % m;
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m7_c <= 6; m7_w <= 0; m7_e <= 0;
      m8_c <= 7; m8_w <= 0; m8_e <= 0;
      ma_c <= 6; mb_c <= 6;
    end else begin
      m7_c <= nxt_count(7, m7_c, int'(load), int'(en), int'(load_val));
      m7_w <= int'(!load && en && m7_c == 0);
      m7_e <= load ? int'(load_val >= 3'd7) : m7_e;
      m8_c <= nxt_count(8, m8_c, int'(load), int'(en), int'(load_val));
      m8_w <= int'(!load && en && m8_c == 0);
      m8_e <= load ? 0 : m8_e;
      ma_c <= nxt_count(7, ma_c, 0, int'(casc_en), 0);
      mb_c <= nxt_count(7, mb_c, 0, int'(casc_en && ma_c == 0), 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("c7", int'(c7), m7_c);
      check("z7", int'(z7), int'(m7_c == 0));
      check("b7", int'(b7), int'(en && m7_c == 0));
      check("w7", int'(w7), m7_w);
      check("e7", int'(e7), m7_e);
      check("c8", int'(c8), m8_c);
      check("z8", int'(z8), int'(m8_c == 0));
      check("b8", int'(b8), int'(en && m8_c == 0));
      check("w8", int'(w8), m8_w);
      check("e8", int'(e8), m8_e);
      check("ca", int'(ca), ma_c);
      check("cb", int'(cb), mb_c);
      check("ba", int'(ba), int'(casc_en && ma_c == 0));
    end
  end

  initial begin
    int exp7[14] = '{5, 4, 3, 2, 1, 0, 6, 5, 4, 3, 2, 1, 0, 6};
    int exp8[14] = '{6, 5, 4, 3, 2, 1, 0, 7, 6, 5, 4, 3, 2, 1};
    int w7cnt = 0;
    int w8cnt = 0;

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Set load_err and move off the reset value so an asynchronous reset is observable.
    @(negedge clk); load = 1'b1; load_val = 3'd7;
    @(negedge clk); load = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2; rst = 1'b1; #1;
    check("async_rst_count", int'(c7), 6);
    check("async_rst_wrap", int'(w7), 0);
    check("async_rst_err", int'(e7), 0);
    check("async_rst_count8", int'(c8), 7);

    @(negedge clk); rst = 1'b0; en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold", int'(c7), 6);
    end

    @(negedge clk); en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      check("run7", int'(c7), exp7[k]);
      check("run8", int'(c8), exp8[k]);
      check("run_zero", int'(z7), int'(exp7[k] == 0));
      w7cnt += int'(w7);
      w8cnt += int'(w8);
    end
    check("wraps7", w7cnt, 2);
    check("wraps8", w8cnt, 1);

    @(negedge clk); load = 1'b1; load_val = 3'd2; en = 1'b1;
    @(posedge clk); #1;
    check("load2", int'(c7), 2);
    check("load2_m8", int'(c8), 2);
    @(negedge clk); load_val = 3'd7;
    @(posedge clk); #1;
    check("load7_count", int'(c7), 6);
    check("load7_err", int'(e7), 1);
    check("load7_m8_count", int'(c8), 7);
    check("load7_m8_err", int'(e8), 0);
    @(negedge clk); load_val = 3'd3;
    @(posedge clk); #1;
    check("load3_count", int'(c7), 3);
    check("load3_err", int'(e7), 0);

    @(negedge clk); load_val = 3'd0;
    @(posedge clk); #1;
    check("at_zero_borrow", int'(b7), 1);
    @(negedge clk); load_val = 3'd4;
    @(posedge clk); #1;
    check("load_over_wrap_count", int'(c7), 4);
    check("load_over_wrap_wrap", int'(w7), 0);

    @(negedge clk); load_val = 3'd2; #3; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_load", int'(c7), 6);
    @(negedge clk); rst = 1'b0; load = 1'b0; en = 1'b0;

    repeat (400) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 7) == 0);
      load_val = 3'($urandom_range(0, 7));
    end
    @(negedge clk); load = 1'b0; en = 1'b0;

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; casc_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("casc6_a", int'(ca), 0);
    check("casc6_b", int'(cb), 6);
    @(posedge clk); #1;
    check("casc7_a", int'(ca), 6);
    check("casc7_b", int'(cb), 5);
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
